// File: rtl/ula_74181_sync_if.sv
// Operand/select/result bundle for the registered 74181-style ALU slice.
// The master drives operands and function select; the slave returns results.
interface ula_74181_sync_if;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
    logic       m;
    logic       c_in;
    logic [3:0] f;
    logic       a_eq_b;
    logic       c_out;

    modport master (
        output a, b, s, m, c_in,
        input  f, a_eq_b, c_out
    );

    modport slave (
        input  a, b, s, m, c_in,
        output f, a_eq_b, c_out
    );
endinterface

// File: rtl/ula_74181_sync.sv
// Registered 4-bit ALU slice with the 74181 logic/arithmetic function set.
// One-cycle latency; carry chains to the next slice through c_in/c_out.
module ula_74181_sync (
    input  logic             clk,
    input  logic             rst_n,
    ula_74181_sync_if.slave  bus
);
    logic [3:0] f_d, f_q;
    logic       c_out_d, c_out_q;
    logic       a_eq_b_d, a_eq_b_q;

    logic [3:0] x, y, lf;
    logic [4:0] sum;

    // Arithmetic mode builds two addend terms from the select bits.
    always_comb begin
        x   = bus.a
            | (bus.b & {4{bus.s[0]}})
            | (~bus.b & {4{bus.s[1]}});
        y   = (bus.a & bus.b & {4{bus.s[3]}})
            | (bus.a & ~bus.b & {4{bus.s[2]}});
        sum = {1'b0, x} + {1'b0, y} + {4'b0, bus.c_in};
    end

    always_comb begin
        lf = 4'h0;
        case (bus.s)
            4'd0:  lf = ~bus.a;
            4'd1:  lf = ~(bus.a | bus.b);
            4'd2:  lf = ~bus.a & bus.b;
            4'd3:  lf = 4'h0;
            4'd4:  lf = ~(bus.a & bus.b);
            4'd5:  lf = ~bus.b;
            4'd6:  lf = bus.a ^ bus.b;
            4'd7:  lf = bus.a & ~bus.b;
            4'd8:  lf = ~bus.a | bus.b;
            4'd9:  lf = ~(bus.a ^ bus.b);
            4'd10: lf = bus.b;
            4'd11: lf = bus.a & bus.b;
            4'd12: lf = 4'hF;
            4'd13: lf = bus.a | ~bus.b;
            4'd14: lf = bus.a | bus.b;
            4'd15: lf = bus.a;
            default: lf = 4'h0;
        endcase
    end

    always_comb begin
        f_d     = sum[3:0];
        c_out_d = sum[4];
        if (bus.m) begin
            f_d     = lf;
            c_out_d = 1'b0;
        end
        a_eq_b_d = (f_d == 4'hF);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f_q      <= 4'h0;
            c_out_q  <= 1'b0;
            a_eq_b_q <= 1'b0;
        end else begin
            f_q      <= f_d;
            c_out_q  <= c_out_d;
            a_eq_b_q <= a_eq_b_d;
        end
    end

    assign bus.f      = f_q;
    assign bus.c_out  = c_out_q;
    assign bus.a_eq_b = a_eq_b_q;
endmodule

// File: tb/tb_ula_74181_sync.sv
// Directed-vector bench for the registered 74181 ALU slice.
// Expected values come from hand-computed tables and an op-list model.
module tb_ula_74181_sync;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    ula_74181_sync_if bus_if ();

    ula_74181_sync dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] s;
        logic       m;
        logic       c_in;
        logic [3:0] f;
        logic       c;
        logic       eq;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [3:0] f_exp,
                       input logic c_exp, input logic eq_exp);
        total++;
        if (bus_if.f !== f_exp || bus_if.c_out !== c_exp
            || bus_if.a_eq_b !== eq_exp) begin
            bad++;
            $display("FAIL %s: got f=%0d c=%b eq=%b want f=%0d c=%b eq=%b",
                     nm, bus_if.f, bus_if.c_out, bus_if.a_eq_b,
                     f_exp, c_exp, eq_exp);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] s, input logic m,
                         input logic ci);
        bus_if.a    = a;
        bus_if.b    = b;
        bus_if.s    = s;
        bus_if.m    = m;
        bus_if.c_in = ci;
    endtask

    // Reference written from the op list, not from the X/Y generator.
    function automatic logic [4:0] ref_arith(input logic [3:0] a,
                                             input logic [3:0] b,
                                             input logic [3:0] s,
                                             input logic ci);
        logic [3:0] p, q, nb;
        nb = ~b;
        p = 4'h0;
        q = 4'h0;
        case (s)
            4'd0:  p = a;
            4'd1:  p = a | b;
            4'd2:  p = a | nb;
            4'd3:  p = 4'hF;
            4'd4:  begin p = a;      q = a & nb; end
            4'd5:  begin p = a | b;  q = a & nb; end
            4'd6:  begin p = a;      q = nb;     end
            4'd7:  begin p = a & nb; q = 4'hF;   end
            4'd8:  begin p = a;      q = a & b;  end
            4'd9:  begin p = a;      q = b;      end
            4'd10: begin p = a | nb; q = a & b;  end
            4'd11: begin p = a & b;  q = 4'hF;   end
            4'd12: begin p = a;      q = a;      end
            4'd13: begin p = a | b;  q = a;      end
            4'd14: begin p = a | nb; q = a;      end
            default: begin p = a;    q = 4'hF;   end
        endcase
        return {1'b0, p} + {1'b0, q} + {4'b0, ci};
    endfunction

    function automatic logic [3:0] ref_logic(input logic [3:0] a,
                                             input logic [3:0] b,
                                             input logic [3:0] s);
        case (s)
            4'd0:  return ~a;
            4'd1:  return ~(a | b);
            4'd2:  return ~a & b;
            4'd3:  return 4'h0;
            4'd4:  return ~(a & b);
            4'd5:  return ~b;
            4'd6:  return a ^ b;
            4'd7:  return a & ~b;
            4'd8:  return ~a | b;
            4'd9:  return ~(a ^ b);
            4'd10: return b;
            4'd11: return a & b;
            4'd12: return 4'hF;
            4'd13: return a | ~b;
            4'd14: return a | b;
            default: return a;
        endcase
    endfunction

    initial begin
        logic [3:0] pf;
        logic       pc, pe;
        logic [4:0] r;
        logic [3:0] ea, eb, ef;
        logic       ec;

        vecs[0]  = '{4'd4, 4'd3, 4'd9,  1'b0, 1'b0, 4'd7,  1'b0, 1'b0};
        vecs[1]  = '{4'd4, 4'd3, 4'd9,  1'b0, 1'b1, 4'd8,  1'b0, 1'b0};
        vecs[2]  = '{4'd4, 4'd3, 4'd6,  1'b0, 1'b0, 4'd0,  1'b1, 1'b0};
        vecs[3]  = '{4'd4, 4'd3, 4'd6,  1'b0, 1'b1, 4'd1,  1'b1, 1'b0};
        vecs[4]  = '{4'd5, 4'd5, 4'd6,  1'b0, 1'b0, 4'd15, 1'b0, 1'b1};
        vecs[5]  = '{4'd4, 4'd3, 4'd3,  1'b0, 1'b0, 4'd15, 1'b0, 1'b1};
        vecs[6]  = '{4'd4, 4'd3, 4'd3,  1'b0, 1'b1, 4'd0,  1'b1, 1'b0};
        vecs[7]  = '{4'd4, 4'd3, 4'd15, 1'b0, 1'b0, 4'd3,  1'b1, 1'b0};
        vecs[8]  = '{4'd4, 4'd3, 4'd0,  1'b1, 1'b1, 4'd11, 1'b0, 1'b0};
        vecs[9]  = '{4'd4, 4'd3, 4'd6,  1'b1, 1'b1, 4'd7,  1'b0, 1'b0};
        vecs[10] = '{4'd4, 4'd3, 4'd11, 1'b1, 1'b1, 4'd0,  1'b0, 1'b0};
        vecs[11] = '{4'd4, 4'd3, 4'd12, 1'b1, 1'b1, 4'd15, 1'b0, 1'b1};
        vecs[12] = '{4'd9, 4'd9, 4'd9,  1'b0, 1'b1, 4'd3,  1'b1, 1'b0};
        vecs[13] = '{4'd0, 4'd0, 4'd15, 1'b0, 1'b0, 4'd15, 1'b0, 1'b1};

        // Reset holds outputs at zero despite inputs that would give 14/carry.
        drive(4'hF, 4'hF, 4'd9, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("reset", 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("reset_hold", 4'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1 chk("reset_release", 4'd14, 1'b1, 1'b0);
        pf = 4'd14; pc = 1'b1; pe = 1'b0;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].m, vecs[i].c_in);
            #1 chk($sformatf("vec%0d_pre", i), pf, pc, pe);
            @(posedge clk);
            #1 chk($sformatf("vec%0d", i), vecs[i].f, vecs[i].c, vecs[i].eq);
            pf = vecs[i].f; pc = vecs[i].c; pe = vecs[i].eq;
        end

        for (int i = 0; i < 64; i++) begin
            ea = 4'((i * 7) + 2);
            eb = 4'((i * 5) + 3);
            @(negedge clk);
            drive(ea, eb, 4'(i), i[5], i[4]);
            if (i[5]) begin
                ef = ref_logic(ea, eb, 4'(i));
                ec = 1'b0;
            end else begin
                r  = ref_arith(ea, eb, 4'(i), i[4]);
                ef = r[3:0];
                ec = r[4];
            end
            #1 chk($sformatf("sweep%0d_pre", i), pf, pc, pe);
            @(posedge clk);
            #1 chk($sformatf("sweep%0d", i), ef, ec, ef == 4'hF);
            pf = ef; pc = ec; pe = (ef == 4'hF);
        end

        // Mid-run reset takes priority over live inputs.
        @(negedge clk);
        drive(4'hF, 4'hF, 4'd12, 1'b1, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 chk("reset_priority", 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("after_reset", 4'd15, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
